rc4_key_search_ctrl: RTL and testbench

//  Scheduler that sweeps the secret-key space through one RC4 init/shuffle/decrypt core.
//  Per candidate: loads a 24-bit key, pulses core_start, waits for core_done and reads the verdict (core_invalid).

---
 rtl/rc4_key_search_ctrl_if.sv | 23 ++
 rtl/rc4_key_search_ctrl.sv | 120 ++++++++++++
 tb/tb_rc4_key_search_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rc4_key_search_ctrl_if.sv
// rtl/rc4_key_search_ctrl_if.sv - launch/verdict handshake between key-search controller and RC4 core
interface rc4_key_search_ctrl_if;
    logic        core_start;
    logic [23:0] core_key;
    logic        core_done;
    logic        core_invalid;

    // Controller side: launches candidates and collects verdicts.
    modport master (
        output core_start,
        output core_key,
        input  core_done,
        input  core_invalid
    );

    // Core side: receives a candidate key and returns a verdict.
    modport slave (
        input  core_start,
        input  core_key,
        output core_done,
        output core_invalid
    );
endinterface

// File: rtl/rc4_key_search_ctrl.sv
// rtl/rc4_key_search_ctrl.sv - sweeps a key range through one RC4 core, stops on first valid key
module rc4_key_search_ctrl #(
    parameter logic [23:0] KEY_FIRST   = 24'h000000,
    parameter logic [23:0] KEY_LAST    = 24'h3FFFFF,
    parameter logic [23:0] KEY_STEP    = 24'h000001,
    parameter int          TIMEOUT_CYC = 4096
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    rc4_key_search_ctrl_if.master core,
    output logic                  busy,
    output logic                  found,
    output logic                  exhausted,
    output logic                  fault,
    output logic [23:0]           found_key,
    output logic [23:0]           keys_tried
);

    localparam int            CW        = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LAUNCH,
        S_WAIT,
        S_EVAL
    } state_t;

    state_t        state;
    logic [CW-1:0] wait_cnt;
    logic          invalid_q;
    logic [24:0]   next_key;

    // Candidate advance is done one bit wide so the end-of-range test never wraps
    // through zero, and KEY_LAST < KEY_STEP cannot underflow.
    assign next_key = {1'b0, core.core_key} + {1'b0, KEY_STEP};

    // Search sequencer; every output is a register updated here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= S_IDLE;
            core.core_start <= 1'b0;
            core.core_key   <= 24'h000000;
            busy            <= 1'b0;
            found           <= 1'b0;
            exhausted       <= 1'b0;
            fault           <= 1'b0;
            found_key       <= 24'h000000;
            keys_tried      <= 24'h000000;
            wait_cnt        <= '0;
            invalid_q       <= 1'b0;
        end else if (abort) begin
            // Abort outranks done, timeout and start; sticky flags stay as they are.
            state           <= S_IDLE;
            core.core_start <= 1'b0;
            busy            <= 1'b0;
        end else begin
            core.core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        found      <= 1'b0;
                        exhausted  <= 1'b0;
                        fault      <= 1'b0;
                        keys_tried <= 24'h000000;
                        busy       <= 1'b1;
                        state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    // core_start is registered, so it is raised here to be high during LAUNCH.
                    core.core_key   <= KEY_FIRST;
                    core.core_start <= 1'b1;
                    state           <= S_LAUNCH;
                end
                S_LAUNCH: begin
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (core.core_done) begin
                        // A done arriving on the last allowed cycle still counts.
                        invalid_q  <= core.core_invalid;
                        keys_tried <= keys_tried + 24'd1;
                        state      <= S_EVAL;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                S_EVAL: begin
                    if (!invalid_q) begin
                        found     <= 1'b1;
                        found_key <= core.core_key;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else if (next_key > {1'b0, KEY_LAST}) begin
                        exhausted <= 1'b1;
                        busy      <= 1'b0;
                        state     <= S_IDLE;
                    end else begin
                        core.core_key   <= next_key[23:0];
                        core.core_start <= 1'b1;
                        state           <= S_LAUNCH;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_key_search_ctrl.sv
// tb/tb_rc4_key_search_ctrl.sv - directed self-checking bench for rc4_key_search_ctrl
module tb_rc4_key_search_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        abort;
    logic [3:0]  st;
    logic [3:0]  en;
    logic [3:0]  inj;
    logic [23:0] vk [4];

    logic [3:0]  busy_w, found_w, exh_w, fault_w, cs_w, done_w;
    logic [23:0] fkey_w  [4];
    logic [23:0] tried_w [4];

    int n_tests = 0;
    int n_fail  = 0;
    int p;

    always #5 clk = ~clk;

    rc4_key_search_ctrl_if bus[4] ();

    rc4_key_search_ctrl #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h3FFFFF), .KEY_STEP(24'h000001), .TIMEOUT_CYC(4096)) u0 (
        .clk(clk), .reset_n(reset_n), .start(st[0]), .abort(abort), .core(bus[0]),
        .busy(busy_w[0]), .found(found_w[0]), .exhausted(exh_w[0]), .fault(fault_w[0]),
        .found_key(fkey_w[0]), .keys_tried(tried_w[0]));

    rc4_key_search_ctrl #(.KEY_FIRST(24'h3FFFFD), .KEY_LAST(24'h3FFFFF), .KEY_STEP(24'h000001), .TIMEOUT_CYC(4096)) u1 (
        .clk(clk), .reset_n(reset_n), .start(st[1]), .abort(abort), .core(bus[1]),
        .busy(busy_w[1]), .found(found_w[1]), .exhausted(exh_w[1]), .fault(fault_w[1]),
        .found_key(fkey_w[1]), .keys_tried(tried_w[1]));

    rc4_key_search_ctrl #(.KEY_FIRST(24'h000000), .KEY_LAST(24'h3FFFFF), .KEY_STEP(24'h000001), .TIMEOUT_CYC(16)) u2 (
        .clk(clk), .reset_n(reset_n), .start(st[2]), .abort(abort), .core(bus[2]),
        .busy(busy_w[2]), .found(found_w[2]), .exhausted(exh_w[2]), .fault(fault_w[2]),
        .found_key(fkey_w[2]), .keys_tried(tried_w[2]));

    rc4_key_search_ctrl #(.KEY_FIRST(24'h000001), .KEY_LAST(24'h000007), .KEY_STEP(24'h000002), .TIMEOUT_CYC(4096)) u3 (
        .clk(clk), .reset_n(reset_n), .start(st[3]), .abort(abort), .core(bus[3]),
        .busy(busy_w[3]), .found(found_w[3]), .exhausted(exh_w[3]), .fault(fault_w[3]),
        .found_key(fkey_w[3]), .keys_tried(tried_w[3]));

    for (genvar i = 0; i < 4; i++) begin : g_core
        logic [2:0]  cnt;
        logic        done_q, inv_q;
        int          npulse;
        logic        saw_even, saw_zero;
        logic [23:0] last_key;

        assign bus[i].core_done    = done_q | inj[i];
        assign bus[i].core_invalid = inv_q;
        assign cs_w[i]             = bus[i].core_start;
        assign done_w[i]           = bus[i].core_done;

        // Model core: answers 4 cycles after core_start; only key vk[i] is valid.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                cnt    <= 3'd0;
                done_q <= 1'b0;
                inv_q  <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (bus[i].core_start && en[i]) begin
                    cnt <= 3'd3;
                end else if (cnt != 3'd0) begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        done_q <= 1'b1;
                        inv_q  <= (bus[i].core_key != vk[i]);
                    end
                end
            end
        end

        // Records every launch: pulse count, last key, even/zero keys presented.
        always @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                npulse   <= 0;
                saw_even <= 1'b0;
                saw_zero <= 1'b0;
                last_key <= 24'h000000;
            end else if (bus[i].core_start) begin
                npulse   <= npulse + 1;
                last_key <= bus[i].core_key;
                if (!bus[i].core_key[0]) saw_even <= 1'b1;
                if (bus[i].core_key == 24'h000000) saw_zero <= 1'b1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_start(input int i);
        @(negedge clk);
        st[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        st[i] = 1'b0;
    endtask

    task automatic wait_idle(input int i, input int max, input string tag);
        bit idle = 1'b0;
        for (int c = 0; c < max && !idle; c++) begin
            cycle();
            if (!busy_w[i]) idle = 1'b1;
        end
        check(tag, 32'(idle), 32'd1);
    endtask

    task automatic wait_cs(input int i, input int max, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < max && !seen; c++) begin
            cycle();
            if (cs_w[i]) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_done(input int i, input int max, input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < max && !seen; c++) begin
            cycle();
            if (done_w[i]) seen = 1'b1;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        reset_n = 1'b0;
        abort   = 1'b0;
        st      = 4'b0000;
        en      = 4'b1011;
        inj     = 4'b0000;
        vk[0]   = 24'h000249;
        vk[1]   = 24'h000000;
        vk[2]   = 24'h000000;
        vk[3]   = 24'h000006;

        repeat (2) @(negedge clk);
        check("rst_busy",   32'(busy_w[0]),    32'd0);
        check("rst_cs",     32'(cs_w[0]),      32'd0);
        check("rst_key",    32'(bus[0].core_key), 32'd0);
        check("rst_tried",  32'(tried_w[0]),   32'd0);
        check("rst_flags",  32'({found_w[0], exh_w[0], fault_w[0]}), 32'd0);
        reset_n = 1'b1;

        // 1: valid key 0x249 reached from 0 with step 1
        p = g_core[0].npulse;
        do_start(0);
        check("t1_load_cs",   32'(cs_w[0]),   32'd0);
        check("t1_load_busy", 32'(busy_w[0]), 32'd1);
        cycle();
        check("t1_launch_cs",  32'(cs_w[0]),           32'd1);
        check("t1_launch_key", 32'(bus[0].core_key),   32'h000000);
        wait_idle(0, 5000, "t1_finish");
        check("t1_found", 32'(found_w[0]), 32'd1);
        check("t1_exh",   32'(exh_w[0]),   32'd0);
        check("t1_fkey",  32'(fkey_w[0]),  32'h000249);
        check("t1_tried", 32'(tried_w[0]), 32'd586);
        check("t1_pulses", 32'(g_core[0].npulse - p), 32'd586);

        // core_done while idle must not count
        @(negedge clk);
        inj[0] = 1'b1;
        cycle();
        inj[0] = 1'b0;
        cycle();
        check("idle_done_ignored", 32'(tried_w[0]), 32'd586);

        // 2: top of range, no wrap to zero
        do_start(1);
        wait_idle(1, 200, "t2_finish");
        check("t2_exh",     32'(exh_w[1]),            32'd1);
        check("t2_found",   32'(found_w[1]),          32'd0);
        check("t2_tried",   32'(tried_w[1]),          32'd3);
        check("t2_lastkey", 32'(g_core[1].last_key),  32'h3FFFFF);
        check("t2_nowrap",  32'(g_core[1].saw_zero),  32'd0);

        // 3: silent core, TIMEOUT_CYC=16
        do_start(2);
        wait_cs(2, 10, "t3_cs");
        for (int k = 1; k <= 17; k++) begin
            cycle();
            if (k == 16) begin
                check("t3_fault_early", 32'(fault_w[2]), 32'd0);
                check("t3_busy_early",  32'(busy_w[2]),  32'd1);
            end
            if (k == 17) begin
                check("t3_fault", 32'(fault_w[2]), 32'd1);
                check("t3_busy",  32'(busy_w[2]),  32'd0);
            end
        end

        // 6: odd keys 1..7, valid key 6 never presented
        do_start(3);
        wait_done(3, 20, "t6_done");
        cycle();
        check("t6_eval_cs",  32'(cs_w[3]), 32'd0);
        cycle();
        check("t6_next_cs",  32'(cs_w[3]),          32'd1);
        check("t6_next_key", 32'(bus[3].core_key),  32'h000003);
        wait_idle(3, 200, "t6_finish");
        check("t6_exh",     32'(exh_w[3]),           32'd1);
        check("t6_found",   32'(found_w[3]),         32'd0);
        check("t6_tried",   32'(tried_w[3]),         32'd4);
        check("t6_lastkey", 32'(g_core[3].last_key), 32'h000007);
        check("t6_odd",     32'(g_core[3].saw_even), 32'd0);

        // 4: abort in the same cycle as a valid core_done
        vk[0] = 24'h000000;
        do_start(0);
        wait_done(0, 20, "t4_done");
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t4_busy",  32'(busy_w[0]),  32'd0);
        check("t4_found", 32'(found_w[0]), 32'd0);
        p = g_core[0].npulse;
        repeat (12) cycle();
        check("t4_no_launch", 32'(g_core[0].npulse - p), 32'd0);
        check("t4_found_late", 32'(found_w[0]), 32'd0);

        // 5: reset mid-WAIT, then restart from KEY_FIRST
        vk[0] = 24'h000249;
        do_start(0);
        wait_cs(0, 10, "t5_cs1");
        wait_cs(0, 20, "t5_cs2");
        wait_cs(0, 20, "t5_cs3");
        cycle();
        reset_n = 1'b0;
        #1;
        check("t5_rst_busy",  32'(busy_w[0]),         32'd0);
        check("t5_rst_key",   32'(bus[0].core_key),   32'd0);
        check("t5_rst_tried", 32'(tried_w[0]),        32'd0);
        check("t5_rst_fkey",  32'(fkey_w[0]),         32'd0);
        check("t5_rst_flags", 32'({found_w[0], exh_w[0], fault_w[0], cs_w[0]}), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        do_start(0);
        cycle();
        check("t5_restart_cs",    32'(cs_w[0]),         32'd1);
        check("t5_restart_key",   32'(bus[0].core_key), 32'h000000);
        check("t5_restart_tried", 32'(tried_w[0]),      32'd0);
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        check("t5_abort_busy", 32'(busy_w[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
